// File: rtl/vga_timing_gen.sv
// Raster timing generator: current/next pixel counters plus registered
// sync, active-video and line/frame strobes aligned with pixel_x/pixel_y.
module vga_timing_gen #(
    parameter int   H_ACTIVE  = 1280,
    parameter int   H_FP      = 72,
    parameter int   H_SYNC    = 128,
    parameter int   H_BP      = 200,
    parameter int   V_ACTIVE  = 800,
    parameter int   V_FP      = 3,
    parameter int   V_SYNC    = 6,
    parameter int   V_BP      = 22,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_ce,
    output logic [10:0] pixel_x,
    output logic [9:0]  pixel_y,
    output logic [10:0] next_pixel_x,
    output logic [9:0]  next_pixel_y,
    output logic        hsync,
    output logic        vsync,
    output logic        video_active,
    output logic        line_start,
    output logic        frame_start
);

    localparam logic [10:0] H_LAST   = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [10:0] HS_FIRST = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0]  VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);

    logic [10:0] pixel_x_q, pixel_x_d, next_x_q, next_x_d;
    logic [9:0]  pixel_y_q, pixel_y_d, next_y_q, next_y_d;
    logic        hsync_q, hsync_d, vsync_q, vsync_d;
    logic        active_q, active_d, line_q, line_d, frame_q, frame_d;

    // Advance the raster on pix_ce; flags are decoded from the coordinate
    // about to be loaded into pixel_*, so they land on the same edge.
    always_comb begin
        pixel_x_d = pixel_x_q;
        pixel_y_d = pixel_y_q;
        next_x_d  = next_x_q;
        next_y_d  = next_y_q;
        hsync_d   = hsync_q;
        vsync_d   = vsync_q;
        active_d  = active_q;
        line_d    = line_q;
        frame_d   = frame_q;
        if (pix_ce) begin
            pixel_x_d = next_x_q;
            pixel_y_d = next_y_q;
            if (next_x_q == H_LAST) begin
                next_x_d = 11'd0;
                next_y_d = (next_y_q == V_LAST) ? 10'd0 : next_y_q + 10'd1;
            end else begin
                next_x_d = next_x_q + 11'd1;
            end
            hsync_d  = (next_x_q >= HS_FIRST && next_x_q <= HS_LAST) ? HSYNC_POL : ~HSYNC_POL;
            vsync_d  = (next_y_q >= VS_FIRST && next_y_q <= VS_LAST) ? VSYNC_POL : ~VSYNC_POL;
            active_d = (next_x_q < H_ACT) && (next_y_q < V_ACT);
            line_d   = (next_x_q == 11'd0);
            frame_d  = (next_x_q == 11'd0) && (next_y_q == 10'd0);
        end
    end

    // State registers; reset parks the raster at (0,0) with both strobes up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_x_q <= 11'd0;
            pixel_y_q <= 10'd0;
            next_x_q  <= 11'd1;
            next_y_q  <= 10'd0;
            hsync_q   <= ~HSYNC_POL;
            vsync_q   <= ~VSYNC_POL;
            active_q  <= 1'b1;
            line_q    <= 1'b1;
            frame_q   <= 1'b1;
        end else begin
            pixel_x_q <= pixel_x_d;
            pixel_y_q <= pixel_y_d;
            next_x_q  <= next_x_d;
            next_y_q  <= next_y_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            active_q  <= active_d;
            line_q    <= line_d;
            frame_q   <= frame_d;
        end
    end

    assign pixel_x      = pixel_x_q;
    assign pixel_y      = pixel_y_q;
    assign next_pixel_x = next_x_q;
    assign next_pixel_y = next_y_q;
    assign hsync        = hsync_q;
    assign vsync        = vsync_q;
    assign video_active = active_q;
    assign line_start   = line_q;
    assign frame_start  = frame_q;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator for the 1280x800 @ 60 Hz display path. It owns the horizontal and vertical counters and drives the current and next pixel coordinates consumed by the sprite/background compositor. The next coordinates run one pixel ahead so the compositor can issue block-RAM addresses a cycle early. It also produces HSYNC, VSYNC, the active-video flag and frame/line strobes for the VGA output stage and game logic.

## Interface

Parameters:
- H_ACTIVE, 1280, visible pixels per line
- H_FP, 72, horizontal front porch
- H_SYNC, 128, horizontal sync width
- H_BP, 200, horizontal back porch (H_TOTAL = 1680)
- V_ACTIVE, 800, visible lines
- V_FP, 3, vertical front porch
- V_SYNC, 6, vertical sync width
- V_BP, 22, vertical back porch (V_TOTAL = 831)
- HSYNC_POL, 0, asserted level of hsync
- VSYNC_POL, 1, asserted level of vsync

Ports:
- clk  in  1  pixel-domain clock
- rst  in  1  reset; asynchronous, active-high
- pix_ce  in  1  pixel clock enable; counters advance only when high
- pixel_x  out  11  current horizontal count, 0..H_TOTAL-1
- pixel_y  out  10  current vertical count, 0..V_TOTAL-1
- next_pixel_x  out  11  horizontal count of the following pixel
- next_pixel_y  out  10  vertical count of the following pixel
- hsync  out  1  horizontal sync, polarity per HSYNC_POL
- vsync  out  1  vertical sync, polarity per VSYNC_POL
- video_active  out  1  high while pixel_x < H_ACTIVE and pixel_y < V_ACTIVE
- line_start  out  1  one-pix_ce pulse when pixel_x == 0
- frame_start  out  1  one-pix_ce pulse when pixel_x == 0 and pixel_y == 0

## Operation

- All outputs are registers. Nothing is decoded combinationally after the flops.
- Each cycle with pix_ce = 1:
  - pixel_x <= next_pixel_x and pixel_y <= next_pixel_y.
  - next_pixel_x <= next_pixel_x + 1, wrapping H_TOTAL-1 -> 0.
  - next_pixel_y increments by 1 only when next_pixel_x wraps. It wraps V_TOTAL-1 -> 0.
- Invariant: (next_pixel_x, next_pixel_y) is always the raster successor of (pixel_x, pixel_y). For example, (1679, 5) -> (0, 6) and (1679, 830) -> (0, 0).
- hsync is asserted while pixel_x is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [1352, 1479]. Otherwise it holds the inactive level.
- vsync is asserted while pixel_y is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = [803, 808]. It is asserted for whole lines, including blanking pixels.
- hsync, vsync, video_active, line_start and frame_start are computed from the next_* registers. They update on the same edge as pixel_x/pixel_y, so they are exactly aligned with the current coordinate.
- line_start and frame_start are high for exactly one pix_ce period:
  - Each asserts on the edge where pixel_x loads 0 (and, for frame_start, pixel_y loads 0).
  - Each deasserts on the next pix_ce edge.
  - If pix_ce stays low, the strobe holds.
- Width rules: counter compares use full-width unsigned values. Counts never exceed H_TOTAL-1 or V_TOTAL-1, so there is no overflow.

## Timing

- Reset values (asynchronous, take effect immediately on rst high):
  - pixel_x = 0, pixel_y = 0.
  - next_pixel_x = 1, next_pixel_y = 0.
  - hsync = !HSYNC_POL, vsync = !VSYNC_POL.
  - video_active = 1, line_start = 1, frame_start = 1.
- The first pix_ce edge after reset release moves to (1, 0) and clears both strobes.
- Reset mid-frame returns every output to its reset value regardless of pix_ce. There are no partial lines or stale strobes after release.
- pix_ce = 0: every register holds. This gives zero advance and no glitches on the sync outputs.
- Latency:
  - next_pixel_* leads pixel_* by exactly one pix_ce period.
  - Sync and active flags have zero latency relative to pixel_*.
- Period: line = 1680 pix_ce cycles; frame = 1680 x 831 = 1,396,080 pix_ce cycles.
- Simultaneous line and frame wrap: both strobes assert on the same edge.

## Test plan

- Reset: assert rst asynchronously mid-cycle -> outputs immediately read (0, 0), next (1, 0), hsync = 1, vsync = 0, video_active = 1, line_start = 1, frame_start = 1. Release with pix_ce = 1 -> the next edge gives (1, 0) with both strobes at 0.
- Line wrap: run to pixel = (1679, 5) -> the next edge gives (0, 6), next = (1, 6), line_start = 1, frame_start = 0. video_active is 0 at x = 1280 and 1 at x = 0.
- Frame wrap: at (1679, 830), next = (0, 0) -> the following edge gives (0, 0), line_start = 1, frame_start = 1. The count of pix_ce edges between successive frame_start pulses is 1,396,080.
- Sync windows: over one frame, hsync is low for exactly x = 1352..1479 (128 cycles per line), and vsync is high for exactly y = 803..808 (6 x 1680 = 10,080 cycles).
- Clock enable: pix_ce = 1 on alternating cycles -> all outputs change only on enabled edges. A pix_ce = 0 burst of 50 cycles at x = 1400 holds hsync low and pixel_x at 1400.
- Reset mid-frame: at (700, 400) assert rst for 3 cycles -> all outputs are at reset values during rst. After release the sequence restarts at (1, 0) with no extra strobe pulse.
